// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the two-requester memory port arbiter.
// The optional MEM_ARB_ROUND_ROBIN_EN build uses req_id_e to track the last grant.
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 11;
    localparam int unsigned DEF_DATA_W = 10;
    localparam int unsigned DEF_DEPTH  = 1024;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_ACK     = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

    function automatic req_id_e other_req(input req_id_e id);
        return (id == REQ_A) ? REQ_B : REQ_A;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: a lone request always wins, a tie goes to
// the requester that was not granted last.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic    a_req_i,
    input  logic    b_req_i,
    input  req_id_e last_grant_i,
    output req_id_e grant_c_o
);

    always_comb begin
        grant_c_o = REQ_A;
        if (a_req_i && b_req_i) begin
            grant_c_o = other_req(last_grant_i);
        end else if (b_req_i) begin
            grant_c_o = REQ_B;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a capture (A) and a readout (B) requester onto one synchronous memory port
// using four-phase handshakes. Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic              clk_100,
    input  logic              rst,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic              a_err,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic              b_err,
    output logic [DATA_W-1:0] b_rdata,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    arb_state_e        state_q, state_d;
    req_id_e           win_q, win_d;
    logic              we_q, we_d;
    logic              oor_q, oor_d;
    logic              a_ack_q, a_ack_d;
    logic              a_err_q, a_err_d;
    logic              b_ack_q, b_ack_d;
    logic              b_err_q, b_err_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;

    req_id_e           grant_c;
    req_id_e           last_grant_c;
    logic              sel_we_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_wdata_c;
    logic              sel_oor_c;
    logic              win_req_c;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    req_id_e           last_grant_q, last_grant_d;
    assign last_grant_c = last_grant_q;
`else
    assign last_grant_c = REQ_B;
`endif

    mem_arb_pick u_pick (
        .a_req_i      (a_req),
        .b_req_i      (b_req),
        .last_grant_i (last_grant_c),
        .grant_c_o    (grant_c)
    );

    assign sel_we_c    = (grant_c == REQ_A) ? a_we    : b_we;
    assign sel_addr_c  = (grant_c == REQ_A) ? a_addr  : b_addr;
    assign sel_wdata_c = (grant_c == REQ_A) ? a_wdata : b_wdata;
    assign sel_oor_c   = (32'(sel_addr_c) >= DEPTH);
    assign win_req_c   = (win_q == REQ_A) ? a_req : b_req;

    // Next-state and registered-output logic; memory port is loaded on the IDLE->ISSUE edge
    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        we_d        = we_q;
        oor_d       = oor_q;
        a_ack_d     = a_ack_q;
        a_err_d     = a_err_q;
        b_ack_d     = b_ack_q;
        b_err_d     = b_err_q;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (a_req || b_req) begin
                    win_d   = grant_c;
                    we_d    = sel_we_c;
                    oor_d   = sel_oor_c;
                    state_d = ST_ISSUE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_grant_d = grant_c;
`endif
                    if (!sel_oor_c) begin
                        mem_addr_d  = sel_addr_c;
                        mem_wdata_d = sel_wdata_c;
                        mem_we_d    = sel_we_c;
                    end
                end
            end

            ST_ISSUE: begin
                if (we_q) begin
                    state_d = ST_ACK;
                    if (win_q == REQ_A) begin
                        a_ack_d = 1'b1;
                        a_err_d = oor_q;
                    end else begin
                        b_ack_d = 1'b1;
                        b_err_d = oor_q;
                    end
                end else begin
                    state_d = ST_CAPTURE;
                end
            end

            ST_CAPTURE: begin
                state_d = ST_ACK;
                if (win_q == REQ_A) begin
                    a_ack_d   = 1'b1;
                    a_err_d   = oor_q;
                    a_rdata_d = oor_q ? '0 : mem_rdata;
                end else begin
                    b_ack_d   = 1'b1;
                    b_err_d   = oor_q;
                    b_rdata_d = oor_q ? '0 : mem_rdata;
                end
            end

            ST_ACK: begin
                if (!win_req_c) begin
                    state_d = ST_IDLE;
                    a_ack_d = 1'b0;
                    a_err_d = 1'b0;
                    b_ack_d = 1'b0;
                    b_err_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            win_q       <= REQ_A;
            we_q        <= 1'b0;
            oor_q       <= 1'b0;
            a_ack_q     <= 1'b0;
            a_err_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            b_err_q     <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            we_q        <= we_d;
            oor_q       <= oor_d;
            a_ack_q     <= a_ack_d;
            a_err_q     <= a_err_d;
            b_ack_q     <= b_ack_d;
            b_err_q     <= b_err_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            last_grant_q <= REQ_B;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign a_ack     = a_ack_q;
    assign a_err     = a_err_q;
    assign a_rdata   = a_rdata_q;
    assign b_ack     = b_ack_q;
    assign b_err     = b_err_q;
    assign b_rdata   = b_rdata_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 11, address width; DATA_W, default 10, sample width; DEPTH, default 1024, valid memory words.
REQ-002 Port clk_100, input, 1, sole clock; all logic SHALL be on its rising edge.
REQ-003 Port rst, input, 1; reset SHALL be asynchronous and active-high.
REQ-004 Port a_req / a_we, input, 1 each, capture requester: request; write(1)/read(0).
REQ-005 Port a_addr / a_wdata, input, ADDR_W / DATA_W, capture address and write data.
REQ-006 Port a_ack / a_err, output, 1 each, capture acknowledge; out-of-range flag.
REQ-007 Port a_rdata, output, DATA_W, capture read data.
REQ-008 Ports b_req, b_we, b_addr, b_wdata, b_ack, b_err, b_rdata SHALL mirror REQ-004..007 for the readout requester.
REQ-009 Port mem_we, output, 1, memory write enable.
REQ-010 Ports mem_addr / mem_wdata, output, ADDR_W / DATA_W, memory address and write data.
REQ-011 Port mem_rdata, input, DATA_W; data is valid the cycle after the address is presented.
REQ-012 Port busy, output, 1, high in any state except IDLE.

Function
REQ-013 Each requester SHALL use four-phase handshake: hold req, arbiter raises ack, requester drops req, arbiter drops ack.
REQ-014 FSM states SHALL be IDLE, ISSUE, CAPTURE, ACK.
REQ-015 IDLE: on any req, pick winner, latch we/addr/wdata, next state ISSUE; otherwise remain.
REQ-016 ISSUE: mem_addr and mem_wdata driven from latch, mem_we = latched we; next state is ACK for write, CAPTURE for read.
REQ-017 CAPTURE: mem_we=0; mem_rdata SHALL be registered into winner's rdata at end of cycle; next state ACK.
REQ-018 ACK: winner's ack=1 and held until its req=0; then next state IDLE with ack low in IDLE.
REQ-019 Latency SHALL be fixed: req high at IDLE edge to ack high is 2 cycles for write, 3 for read.
REQ-020 Outside ISSUE, mem_we SHALL be 0; mem_addr/mem_wdata hold last value.
REQ-021 Address >= DEPTH: no memory access (mem_we=0 in ISSUE), rdata forced 0, err=1 with ack; err cleared on return to IDLE.
REQ-022 Loser's req SHALL be ignored until the arbiter is back in IDLE; it is never dropped.
REQ-023 Req withdrawn after latching: transaction still completes; ack pulses one cycle, then IDLE.
REQ-024 Each rdata SHALL hold its value until overwritten by that requester's next read.

Reset
REQ-025 On rst: state IDLE, all acks/errs 0, mem_we 0, mem_addr 0, mem_wdata 0, rdata 0, busy 0, last-grant = B.
REQ-026 Reset asserted mid-transaction SHALL abort it immediately; no write completes after rst rises.

Configuration
REQ-027 Macro MEM_ARB_ROUND_ROBIN_EN defined: on simultaneous req, grant the requester not granted last; single req always wins.
REQ-028 Macro undefined: fixed priority, A (capture) always wins ties; last-grant register absent.

Structure
REQ-029 Package mem_arb_pkg SHALL hold the state enum, requester-id enum, and default ADDR_W/DATA_W/DEPTH constants.
REQ-030 Winner selection SHALL live in combinational sub-module mem_arb_pick (inputs a_req, b_req, last-grant; output grant id).

Verification
REQ-031 A write addr 5 data 0x2A5 -> mem_we=1 one cycle with mem_addr=5, a_ack 2 cycles after req.
REQ-032 B read addr 5 after REQ-031 -> b_rdata=0x2A5, b_ack 3 cycles after req, held until b_req drops.
REQ-033 A and B req same cycle, twice back-to-back -> round-robin: A then B; fixed: A both times, B served after.
REQ-034 B read addr 1024 -> no mem access, b_rdata=0, b_err=1 with b_ack.
REQ-035 rst raised during ISSUE of A write -> mem_we falls same cycle, all outputs reset, next req served normally.
